serial_addsub: RTL

- Bit-serial add/subtract unit: the sequential counterpart of the 4-bit ripple-carry adder.
- Processes one bit per clock, LSB first, through a single full-adder slice plus a carry flip-flop.
- Used where area matters more than latency, and as the datapath of later multi-cycle arithmetic labs.
- Start/done handshake; result is held stable in an output register.

---
 rtl/serial_addsub_if.sv | 25 ++
 rtl/serial_addsub.sv | 97 +++++++++
 2 files changed

// File: rtl/serial_addsub_if.sv
// Start/done handshake and operand/result bus of the bit-serial add/subtract unit.
// The master side issues operations; the slave side is the arithmetic unit.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, result, cout
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, result, cout
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flip-flop,
// LSB first, WIDTH clocks per operation, result held in an output register.
module serial_addsub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    serial_addsub_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] psum;
    logic [CNT_W-1:0] cnt;
    logic             sub_l;
    logic             carry;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             bb;
    logic             s;
    logic             cy;
    logic [WIDTH-1:0] psum_full;

    // Subtraction is a + ~b + ~borrow_in; the borrow-out is the inverted carry.
    always_comb begin
        bb        = b_sh[0] ^ sub_l;
        s         = a_sh[0] ^ bb ^ carry;
        cy        = (a_sh[0] & bb) | (a_sh[0] & carry) | (bb & carry);
        psum_full = {s, psum};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            psum     <= '0;
            cnt      <= '0;
            sub_l    <= 1'b0;
            carry    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        sub_l  <= bus.sub;
                        carry  <= bus.cin ^ bus.sub;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    carry <= cy;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    psum  <= psum_full[WIDTH-1:1];
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        result_q <= psum_full;
                        cout_q   <= cy ^ sub_l;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
endmodule
